// File: rtl/ysyx_22050612_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050612_pkg
// Brief    : Shared encodings and constants for the npc memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22050612_pkg;

    localparam int c_STRB_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050612_arb_prio.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050612_arb_prio
// Brief    : LSU-priority grant with a starvation escape for the IFU.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050612_arb_prio #(
    parameter int LS_BURST_MAX = 4,
    parameter int CNT_W        = 3
) (
    input  logic             if_req_valid,
    input  logic             ls_req_valid,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_if,
    output logic             grant_ls
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(LS_BURST_MAX);

    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        // Once the IFU has watched LS_BURST_MAX LSU grants go by, it wins once.
        if (ls_req_valid && !(if_req_valid && (starve_cnt == c_CNT_MAX))) begin
            grant_ls = 1'b1;
        end else if (if_req_valid) begin
            grant_if = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22050612_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050612_mem_arbiter
// Brief    : Single-outstanding IFU/LSU arbiter for the npc memory port.
//            Optional watchdog: YSYX_22050612_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050612_mem_arbiter
    import ysyx_22050612_pkg::*;
#(
    parameter int AW             = 64,
    parameter int DW             = 64,
    parameter int LS_BURST_MAX   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [AW-1:0]       if_addr,
    output logic                if_resp_valid,
    output logic [DW-1:0]       if_rdata,
    output logic                if_err,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [AW-1:0]       ls_addr,
    input  logic                ls_wen,
    input  logic [DW-1:0]       ls_wdata,
    input  logic [c_STRB_W-1:0] ls_wmask,
    output logic                ls_resp_valid,
    output logic [DW-1:0]       ls_rdata,
    output logic                ls_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_wen,
    output logic [DW-1:0]       mem_wdata,
    output logic [c_STRB_W-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DW-1:0]       mem_rdata
);

    localparam int                    c_STARVE_W   = $clog2(LS_BURST_MAX + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(LS_BURST_MAX);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    owner_t                r_owner;
    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic [AW-1:0]         r_addr;
    logic                  r_wen;
    logic [DW-1:0]         r_wdata;
    logic [c_STRB_W-1:0]   r_wmask;
    logic                  r_if_resp_valid;
    logic                  r_ls_resp_valid;
    logic [DW-1:0]         r_if_rdata;
    logic [DW-1:0]         r_ls_rdata;
    logic                  w_grant_if;
    logic                  w_grant_ls;
    logic                  w_idle;
    logic                  w_take_if;
    logic                  w_take_ls;
    logic                  w_resp_hit;
    logic                  w_timeout;
    logic                  w_done;
    logic [DW-1:0]         w_resp_data;

    ysyx_22050612_arb_prio #(
        .LS_BURST_MAX (LS_BURST_MAX),
        .CNT_W        (c_STARVE_W)
    ) u_prio (
        .if_req_valid (if_req_valid),
        .ls_req_valid (ls_req_valid),
        .starve_cnt   (r_starve_cnt),
        .grant_if     (w_grant_if),
        .grant_ls     (w_grant_ls)
    );

    assign w_idle      = (r_state == ST_IDLE);
    assign w_take_if   = w_idle & w_grant_if;
    assign w_take_ls   = w_idle & w_grant_ls;
    assign w_resp_hit  = (r_state == ST_WAIT) & mem_resp_valid;
    assign w_done      = w_resp_hit | w_timeout;
    assign w_resp_data = w_resp_hit ? mem_rdata : '1;

`ifdef YSYX_22050612_ARB_TIMEOUT_EN
    localparam int                  c_WDOG_W    = f_max(8, $clog2(TIMEOUT_CYCLES + 1));
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_if_err;
    logic                r_ls_err;
    logic                w_err_fire;

    // The watchdog only runs while a transaction is outstanding.
    assign w_timeout  = ~w_idle & (r_wdog == c_WDOG_LAST);
    assign w_err_fire = w_timeout & ~w_resp_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog   <= '0;
            r_if_err <= 1'b0;
            r_ls_err <= 1'b0;
        end else begin
            r_wdog   <= w_idle ? '0 : r_wdog + c_WDOG_W'(1);
            r_if_err <= w_err_fire & (r_owner == OWN_IF);
            r_ls_err <= w_err_fire & (r_owner == OWN_LS);
        end
    end

    assign if_err = r_if_err;
    assign ls_err = r_ls_err;
`else
    // Never fires; keeps the parameter referenced in this build.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
    assign if_err    = 1'b0;
    assign ls_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_take_if || w_take_ls) w_state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (w_timeout)          w_state_nxt = ST_IDLE;
                else if (mem_req_ready) w_state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (w_done) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= OWN_NONE;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_take_ls) begin
            r_owner <= OWN_LS;
            r_addr  <= ls_addr;
            r_wen   <= ls_wen;
            r_wdata <= ls_wdata;
            r_wmask <= ls_wmask;
        end else if (w_take_if) begin
            r_owner <= OWN_IF;
            r_addr  <= if_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_done) begin
            r_owner <= OWN_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (w_idle) begin
            if (!if_req_valid || w_grant_if) begin
                r_starve_cnt <= '0;
            end else if (w_grant_ls && (r_starve_cnt != c_STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + c_STARVE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_resp_valid <= 1'b0;
            r_ls_resp_valid <= 1'b0;
            r_if_rdata      <= '0;
            r_ls_rdata      <= '0;
        end else begin
            r_if_resp_valid <= w_done & (r_owner == OWN_IF);
            r_ls_resp_valid <= w_done & (r_owner == OWN_LS);
            if (w_done && (r_owner == OWN_IF)) r_if_rdata <= w_resp_data;
            if (w_done && (r_owner == OWN_LS)) r_ls_rdata <= w_resp_data;
        end
    end

    assign if_req_ready  = w_take_if;
    assign ls_req_ready  = w_take_ls;
    assign if_resp_valid = r_if_resp_valid;
    assign ls_resp_valid = r_ls_resp_valid;
    assign if_rdata      = r_if_rdata;
    assign ls_rdata      = r_ls_rdata;
    assign mem_req_valid = (r_state == ST_ISSUE);
    assign mem_addr      = r_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050612_mem_arbiter
// Brief    : Directed self-checking bench for the IFU/LSU memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050612_mem_arbiter;

    localparam int c_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [63:0] if_addr = '0;
    logic        if_resp_valid;
    logic [63:0] if_rdata;
    logic        if_err;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_ready;
    logic [63:0] ls_addr = '0;
    logic        ls_wen = 1'b0;
    logic [63:0] ls_wdata = '0;
    logic [7:0]  ls_wmask = '0;
    logic        ls_resp_valid;
    logic [63:0] ls_rdata;
    logic        ls_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    ysyx_22050612_mem_arbiter #(
        .AW             (64),
        .DW             (64),
        .LS_BURST_MAX   (4),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_addr        (if_addr),
        .if_resp_valid  (if_resp_valid),
        .if_rdata       (if_rdata),
        .if_err         (if_err),
        .ls_req_valid   (ls_req_valid),
        .ls_req_ready   (ls_req_ready),
        .ls_addr        (ls_addr),
        .ls_wen         (ls_wen),
        .ls_wdata       (ls_wdata),
        .ls_wmask       (ls_wmask),
        .ls_resp_valid  (ls_resp_valid),
        .ls_rdata       (ls_rdata),
        .ls_err         (ls_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [1:0] exp_grant [6];
    logic       seen;
    int         seen_at;
    logic [63:0] seen_rdata;
    logic       seen_err;

    initial begin
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01;
        exp_grant[3] = 2'b01; exp_grant[4] = 2'b10; exp_grant[5] = 2'b01;

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_readys", {if_req_ready, ls_req_ready}, 2'b00);
        chk("rst_valids", {mem_req_valid, if_resp_valid, ls_resp_valid}, 3'b000);
        chk("rst_errs", {if_err, ls_err}, 2'b00);
        chk("rst_mem_fields", {mem_addr ^ mem_wdata, 8'(mem_wmask) ^ 8'(mem_wen)}, '0);
        chk("rst_rdata", if_rdata | ls_rdata, 64'h0);
        step();
        step();
        rst = 1'b1;

        // IFU alone, minimum latency
        step(); if_req_valid = 1'b1; if_addr = 64'h8000_0000; mem_req_ready = 1'b1; #1;
        chk("t1_if_ready", if_req_ready, 1'b1);
        chk("t1_ls_ready", ls_req_ready, 1'b0);
        step(); if_req_valid = 1'b0; #1;
        chk("t1_mem_valid", mem_req_valid, 1'b1);
        chk("t1_mem_addr", mem_addr, 64'h8000_0000);
        chk("t1_mem_wen", mem_wen, 1'b0);
        step(); mem_resp_valid = 1'b1; mem_rdata = 64'h0010_0073; #1;
        chk("t1_mem_valid_drop", mem_req_valid, 1'b0);
        chk("t1_no_early_resp", if_resp_valid, 1'b0);
        step(); mem_resp_valid = 1'b0; #1;
        chk("t1_if_resp", if_resp_valid, 1'b1);
        chk("t1_if_rdata", if_rdata, 64'h0010_0073);
        chk("t1_ls_quiet", ls_resp_valid, 1'b0);
        step(); #1;
        chk("t1_pulse_end", if_resp_valid, 1'b0);

        // Simultaneous requests: LSU first, IFU on the next IDLE
        step();
        ls_req_valid = 1'b1; ls_addr = 64'h8000_0100; ls_wen = 1'b0;
        if_req_valid = 1'b1; if_addr = 64'h8000_0004; #1;
        chk("t2_grant_ls", {if_req_ready, ls_req_ready}, 2'b01);
        step(); ls_req_valid = 1'b0; #1;
        chk("t2_ls_addr", mem_addr, 64'h8000_0100);
        chk("t2_if_blocked", if_req_ready, 1'b0);
        step(); mem_resp_valid = 1'b1; mem_rdata = 64'h1111; #1;
        chk("t2_if_blocked_wait", if_req_ready, 1'b0);
        step(); mem_resp_valid = 1'b0; #1;
        chk("t2_ls_resp", {if_resp_valid, ls_resp_valid}, 2'b01);
        chk("t2_ls_rdata", ls_rdata, 64'h1111);
        chk("t2_if_rdata_hold", if_rdata, 64'h0010_0073);
        chk("t2_grant_if", {if_req_ready, ls_req_ready}, 2'b10);
        step(); if_req_valid = 1'b0; #1;
        chk("t2_if_addr", mem_addr, 64'h8000_0004);
        chk("t2_if_wmask", mem_wmask, 8'h00);
        step(); mem_resp_valid = 1'b1; mem_rdata = 64'h2222; #1;
        step(); mem_resp_valid = 1'b0; #1;
        chk("t2_if_resp", {if_resp_valid, ls_resp_valid}, 2'b10);
        chk("t2_if_rdata", if_rdata, 64'h2222);
        chk("t2_ls_rdata_hold", ls_rdata, 64'h1111);

        // Continuous contention: LS,LS,LS,LS,IF,LS
        step();
        ls_req_valid = 1'b1; ls_addr = 64'h8000_2000;
        if_req_valid = 1'b1; if_addr = 64'h8000_0008; #1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t3_grant%0d", i), {if_req_ready, ls_req_ready}, exp_grant[i]);
            step(); #1;
            chk($sformatf("t3_addr%0d", i), mem_addr,
                (exp_grant[i] == 2'b10) ? 64'h8000_0008 : 64'h8000_2000);
            step(); mem_resp_valid = 1'b1; mem_rdata = 64'(i + 16); #1;
            step(); mem_resp_valid = 1'b0; #1;
            chk($sformatf("t3_resp%0d", i), {if_resp_valid, ls_resp_valid}, exp_grant[i]);
        end
        ls_req_valid = 1'b0;
        if_req_valid = 1'b0;
        #1;
        chk("t3_released", {if_req_ready, ls_req_ready}, 2'b00);

        // Stalled store: fields stay put while mem_req_ready is low
        step();
        ls_req_valid = 1'b1; ls_addr = 64'h8000_1000; ls_wen = 1'b1;
        ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F; mem_req_ready = 1'b0; #1;
        chk("t4_grant", ls_req_ready, 1'b1);
        step();
        ls_req_valid = 1'b0; ls_addr = '1; ls_wdata = '0; ls_wmask = 8'h00; ls_wen = 1'b0; #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t4_valid_wen%0d", k), {mem_req_valid, mem_wen}, 2'b11);
            chk($sformatf("t4_addr%0d", k), mem_addr, 64'h8000_1000);
            chk($sformatf("t4_wdata%0d", k), mem_wdata, 64'hDEAD_BEEF);
            chk($sformatf("t4_wmask%0d", k), mem_wmask, 8'h0F);
            step(); #1;
        end
        mem_req_ready = 1'b1; #1;
        chk("t4_still_valid", mem_req_valid, 1'b1);
        step(); mem_req_ready = 1'b0; #1;
        chk("t4_valid_drop", mem_req_valid, 1'b0);
        chk("t4_no_early_resp", ls_resp_valid, 1'b0);
        mem_resp_valid = 1'b1; mem_rdata = 64'h5555;
        step(); mem_resp_valid = 1'b0; #1;
        chk("t4_ls_resp", {if_resp_valid, ls_resp_valid, ls_err}, 3'b010);
        step(); #1;
        chk("t4_pulse_end", ls_resp_valid, 1'b0);

        // Reset during WAIT drops the transaction
        step(); if_req_valid = 1'b1; if_addr = 64'h8000_0010; mem_req_ready = 1'b1; #1;
        step(); if_req_valid = 1'b0; #1;
        step(); #1;
        rst = 1'b0; #1;
        chk("t5_rst_quiet", {mem_req_valid, if_req_ready, ls_req_ready}, 3'b000);
        step(); rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'h9999; #1;
        step(); mem_resp_valid = 1'b0; #1;
        chk("t5_no_resp", {if_resp_valid, ls_resp_valid}, 2'b00);
        chk("t5_rdata_cleared", if_rdata, 64'h0);
        if_req_valid = 1'b1; #1;
        chk("t5_idle_grant", if_req_ready, 1'b1);
        if_req_valid = 1'b0; #1;

        // Memory that never answers
        step(); if_req_valid = 1'b1; if_addr = 64'h8000_0020; mem_req_ready = 1'b1; #1;
        step(); if_req_valid = 1'b0; #1;
        seen = 1'b0; seen_at = 0; seen_rdata = '0; seen_err = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 150) ls_req_valid = 1'b1;
            #1;
            if (if_resp_valid && !seen) begin
                seen = 1'b1; seen_at = k; seen_rdata = if_rdata; seen_err = if_err;
            end
        end
`ifdef YSYX_22050612_ARB_TIMEOUT_EN
        chk("t6_timeout_seen", seen, 1'b1);
        chk("t6_timeout_cycle", 64'(seen_at), 64'(c_TIMEOUT));
        chk("t6_timeout_rdata", seen_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6_timeout_err", seen_err, 1'b1);
`else
        chk("t6_never_resp", seen, 1'b0);
        chk("t6_no_err", if_err, 1'b0);
        chk("t6_ls_blocked", ls_req_ready, 1'b0);
`endif
        ls_req_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22050612_mem_arbiter.md
Name: ysyx_22050612_mem_arbiter

Overview:
- Shares the single memory port of the npc core between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Sequences one transaction at a time: arbitrate, issue, wait for response, route the response back to the owner.
- Sits between the IFU/EXU memory interfaces and the memory model/bus.
- LSU has priority; a starvation counter guarantees IFU forward progress.

Parameters:
- AW, 64, address width (matches the `ysyx_22050612_rgsize` register width).
- DW, 64, data width.
- LS_BURST_MAX, 4, max consecutive LSU grants while IFU is waiting; must be ≥ 1.
- TIMEOUT_CYCLES, 255, watchdog limit, used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- if_req_valid  in  1  IFU request
- if_req_ready  out  1  IFU request accepted
- if_addr  in  AW  fetch address
- if_resp_valid  out  1  IFU response, 1-cycle pulse
- if_rdata  out  DW  fetched data
- if_err  out  1  IFU error, with if_resp_valid
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU request accepted
- ls_addr  in  AW  data address
- ls_wen  in  1  1 = write
- ls_wdata  in  DW  store data
- ls_wmask  in  8  byte strobes
- ls_resp_valid  out  1  LSU response pulse; sent for writes too
- ls_rdata  out  DW  load data
- ls_err  out  1  LSU error, with ls_resp_valid
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  AW  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  DW  latched write data
- mem_wmask  out  8  latched strobes
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DW  memory read data

Behaviour:
- Reset (rst low, async):
  - state=IDLE, owner=NONE, starve_cnt=0.
  - All valid/ready/err outputs 0; all data/address outputs 0.
  - Reset mid-transaction drops it silently; no response is ever delivered for it.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Grant LSU if ls_req_valid and not (if_req_valid and starve_cnt==LS_BURST_MAX); otherwise grant IFU if if_req_valid.
  - The grant cycle asserts the granted *_req_ready combinationally, latches addr/wen/wdata/wmask into the request register, records owner, and goes to ISSUE.
  - IFU grants force wen=0 and wmask=0.
  - Never both readys in one cycle.
- starve_cnt:
  - Increments on each LSU grant while if_req_valid=1.
  - Clears on any IFU grant, or when if_req_valid=0 in IDLE.
  - Saturates at LS_BURST_MAX.
- ISSUE:
  - mem_req_valid=1 with latched fields, held stable until mem_req_ready.
  - On mem_req_ready go to WAIT; mem_req_valid deasserts next cycle.
- WAIT:
  - On mem_resp_valid, drive the owner's *_resp_valid=1 for exactly one cycle, with *_rdata=mem_rdata (registered, so the pulse follows mem_resp_valid by 1 cycle).
  - Then go to IDLE, owner=NONE.
  - The non-owner's resp_valid stays 0; its rdata holds its previous value.
- mem_resp_valid in IDLE or ISSUE is ignored.
- Same-cycle response and new request: the new request is not granted until the cycle after returning to IDLE. One outstanding transaction max.
- Minimum latency, ready/resp immediate: req accepted cycle T, mem_req_valid T+1, mem_resp_valid T+2, resp_valid T+3.
- Requesters hold valid and fields until ready; the arbiter never drops an accepted request.

Optional Feature:
- Macro: YSYX_22050612_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit watchdog counts cycles spent in ISSUE+WAIT; it clears on each IDLE→ISSUE.
  - On reaching TIMEOUT_CYCLES, deliver the owner's resp_valid with rdata=all ones and *_err=1, then return to IDLE.
  - A late mem_resp_valid for the abandoned transaction is ignored.
- Undefined: no counter; the arbiter waits indefinitely; if_err/ls_err are tied 0. Ports are identical either way.

Decomposition:
- Shared package ysyx_22050612_pkg holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2
  - owner encoding: NONE, IF, LS
  - the 8-bit strobe width constant
- One natural sub-module, ysyx_22050612_arb_prio: combinational grant logic from {if_req_valid, ls_req_valid, starve_cnt} producing the grant. The FSM, request register and watchdog stay in the top.

Test Plan:
- IFU alone: if_addr=0x80000000, memory ready immediately, resp next cycle with rdata=0x00100073 → if_req_ready at T, mem_req_valid at T+1, if_resp_valid at T+3 with if_rdata=0x00100073; ls_resp_valid stays 0.
- Simultaneous requests, starve_cnt=0 → LSU granted first (ls_req_ready=1, if_req_ready=0); IFU granted on the next IDLE.
- Continuous ls_req_valid with if_req_valid held, LS_BURST_MAX=4 → grants LS,LS,LS,LS,IF,LS…; the IFU wait never exceeds 4 transactions.
- LSU store addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, mem_req_ready low for 5 cycles → mem fields stable all 5 cycles; ls_resp_valid pulses once after the response.
- rst pulled low during WAIT, then mem_resp_valid arrives after release → no resp_valid on either side; state is IDLE.
- With YSYX_22050612_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, memory never responds → owner resp_valid=1, err=1, rdata=0xFFFFFFFFFFFFFFFF, 16 cycles after issue; without the macro, no response ever.
